// File: rtl/mul4_seq.sv
// mul4_seq: sequential 4x4 unsigned shift-and-add multiplier.
//
// Ports:
//   clk      - clock, rising-edge active
//   rst_n    - asynchronous active-low reset
//   start    - begin a multiply (accepted only when idle)
//   a        - 4-bit multiplicand, captured on accept
//   b        - 4-bit multiplier, captured on accept
//   busy     - high while a multiply is in progress (CALC or DONE)
//   done     - one-cycle pulse when a result is written to product
//   product  - 8-bit result of the last completed multiply, held until the next one
//
// Build option:
//   MUL4_SEQ_ZERO_SKIP_EN - when defined, a zero operand goes straight to DONE
//                           with product=0 instead of running the four steps.

module mul4_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned RES_W = 2 * OP_W;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [OP_W-1:0]    m;
    logic [OP_W-1:0]    h;
    logic [OP_W-1:0]    l;
    logic               c;
    logic [CNT_W-1:0]   cnt;
    logic [OP_W:0]      add_sum;
    logic [OP_W:0]      ch_step;
    logic               last_step;
    logic               accept;
    logic               zero_op;
    logic               busy_next;
    logic               done_next;

`ifdef MUL4_SEQ_ZERO_SKIP_EN
    assign zero_op = (a == OP_W'(0)) || (b == OP_W'(0));
`else
    assign zero_op = 1'b0;
`endif

    assign accept    = (state == IDLE) && start;
    assign last_step = (cnt == CNT_W'(3));

    // Single shared 4-bit adder with carry-out; C is always 0 entering a step,
    // so {C,H} is the zero-extended H on the no-add path.
    always_comb begin
        add_sum = {1'b0, h} + {1'b0, m};
        ch_step = l[0] ? add_sum : {c, h};
    end

    // State register plus registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = zero_op ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode, registered alongside the state
    always_comb begin
        busy_next = 1'b0;
        done_next = 1'b0;
        if (state_next != IDLE) begin
            busy_next = 1'b1;
        end
        if (state_next == DONE) begin
            done_next = 1'b1;
        end
    end

    // Datapath: operand capture, add/shift steps, result load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '0;
            h       <= '0;
            l       <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            m   <= a;
            l   <= b;
            h   <= '0;
            c   <= 1'b0;
            cnt <= '0;
            if (zero_op) begin
                product <= '0;
            end
        end else if (state == CALC) begin
            // {C,H,L} <= {ch_step, L} >> 1; the counter wraps to 0 on the last step
            c   <= 1'b0;
            h   <= ch_step[OP_W:1];
            l   <= {ch_step[0], l[OP_W-1:1]};
            cnt <= cnt + CNT_W'(1);
            if (last_step) begin
                product <= RES_W'({ch_step, l[OP_W-1:1]});
            end
        end
    end

endmodule

// File: tb/tb_mul4_seq.sv
// tb_mul4_seq: scoreboard bench for mul4_seq. Stimulus predicts accepts and
// results from plain arithmetic; a negedge monitor checks done/product/busy.

module tb_mul4_seq;

`ifdef MUL4_SEQ_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    typedef struct {
        int         de;
        logic [7:0] p;
    } exp_t;

    exp_t       sb[$];
    int         cyc       = 0;
    int         checks    = 0;
    int         errors    = 0;
    int         free_at   = 0;
    int         busy_from = 1;
    int         busy_to   = 0;
    logic [7:0] prod_exp  = 8'h00;
    logic       mon_exp_done;

    mul4_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs; the model decides whether the next edge accepts
    task automatic drive(input logic s, input logic [3:0] av, input logic [3:0] bv);
        int   k;
        int   lat;
        exp_t e;
        start = s;
        a     = av;
        b     = bv;
        k     = cyc + 1;
        if (s && rst_n && k >= free_at) begin
            lat       = (ZS && (av == 4'd0 || bv == 4'd0)) ? 1 : 5;
            e.de      = k + lat - 1;
            e.p       = 8'(av) * 8'(bv);
            sb.push_back(e);
            busy_from = k;
            busy_to   = k + lat - 1;
            free_at   = k + lat + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'($urandom), 4'($urandom));
    endtask

    task automatic reset_model();
        sb.delete();
        busy_from = 1;
        busy_to   = 0;
        prod_exp  = 8'h00;
    endtask

    // Monitor: expected done edge and product come from the scoreboard
    always @(negedge clk) begin
        mon_exp_done = (sb.size() > 0) && (sb[0].de == cyc);
        check("done", 32'(done), 32'(mon_exp_done));
        if (mon_exp_done) begin
            check("product_at_done", 32'(product), 32'(sb[0].p));
            prod_exp = sb[0].p;
            void'(sb.pop_front());
        end else begin
            check("product_hold", 32'(product), 32'(prod_exp));
        end
        check("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_to));
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        free_at = cyc + 1;

        // 15*15, full latency and busy window
        drive(1'b1, 4'd15, 4'd15);
        idle(6);

        // 10*12 then 1*1, first result held until the second done
        drive(1'b1, 4'd10, 4'd12);
        drive(1'b0, 4'd0, 4'd0);
        idle(5);
        drive(1'b1, 4'd1, 4'd1);
        idle(6);

        // start held high: accepts only from IDLE, every 6 edges
        for (int i = 0; i < 14; i++) drive(1'b1, 4'd3, 4'd5);
        idle(6);

        // operands change to zero during CALC
        drive(1'b1, 4'd9, 4'd7);
        for (int i = 0; i < 6; i++) drive(1'b0, 4'd0, 4'd0);

        // asynchronous reset around the 2nd CALC edge aborts the operation
        drive(1'b1, 4'd4, 4'd6);
        drive(1'b0, 4'd4, 4'd6);
        #3;
        rst_n = 1'b0;
        reset_model();
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        free_at = cyc + 1;
        drive(1'b1, 4'd2, 4'd3);
        idle(6);

        // zero operand: latency depends on the build option
        drive(1'b1, 4'd0, 4'd9);
        idle(6);
        drive(1'b1, 4'd6, 4'd0);
        idle(6);

        // randomized requests, operands and mid-operation input churn
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
        end
        drive(1'b1, 4'd15, 4'd1);
        idle(8);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul4_seq.md
MUL4_SEQ -- requirements
Module: mul4_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request to begin a multiply, sampled on the rising edge of clk.
REQ-004 The block SHALL have the port a, input, 4 bits: multiplicand, unsigned, captured when start is accepted.
REQ-005 The block SHALL have the port b, input, 4 bits: multiplier, unsigned, captured when start is accepted.
REQ-006 The block SHALL have the port busy, output, 1 bit: high while in CALC or DONE.
REQ-007 The block SHALL have the port done, output, 1 bit: one-cycle pulse, high while in DONE.
REQ-008 The block SHALL have the port product, output, 8 bits: last completed result, registered.

Function
REQ-009 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-010 In IDLE with start=1 at an edge, the block SHALL load M=a, L=b, H=0, C=0, step count=0, and go to CALC.
REQ-011 The block SHALL share one 4-bit adder (H + M, sum plus carry-out) across all steps; no second adder or multiplier primitive is allowed.
REQ-012 Each CALC edge: if L[0]=1, {C,H} SHALL take the 5-bit value H+M; otherwise {C,H} SHALL take {0,H}.
REQ-013 On the same CALC edge, {C,H,L} SHALL then be shifted right by one, and the step count SHALL increment.
REQ-014 After the 4th CALC edge, the FSM SHALL enter DONE, and product SHALL load {H,L} from the final step, giving the exact 8-bit product with no overflow (max 15*15=225).
REQ-015 Latency SHALL be 5 edges from start acceptance to done=1, with no zero-skip: acceptance at E0, CALC at E1..E4, DONE entered at E4.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-017 start SHALL be ignored in CALC and DONE; a new request can be accepted only from IDLE, so back-to-back accepts are spaced 6 edges apart.
REQ-018 Changes on a and b after acceptance SHALL NOT affect the result in progress.
REQ-019 product SHALL hold its value until the next completion, including through IDLE and CALC.
REQ-020 The step counter SHALL be 2 bits and SHALL wrap to 0 on DONE entry.

Reset
REQ-021 While rst_n=0, the FSM SHALL be in IDLE and busy, done, product, M, H, L, C and the step count SHALL all be 0, independent of clk.
REQ-022 When rst_n is asserted mid-CALC or in DONE, the block SHALL abort the operation immediately; no done pulse is produced and product=0.
REQ-023 On the first edge after rst_n deasserts with start=1, the block SHALL accept the request normally.

Configuration
REQ-024 The macro MUL4_SEQ_ZERO_SKIP_EN SHALL control zero-skip.
REQ-025 With MUL4_SEQ_ZERO_SKIP_EN defined, a start accepted with a=0 or b=0 SHALL go directly IDLE->DONE, with product=0 and done at the acceptance edge+1 (1-edge latency).
REQ-026 With MUL4_SEQ_ZERO_SKIP_EN undefined, zero operands SHALL take the full 4 CALC steps (REQ-015).
REQ-027 Nonzero operands SHALL behave identically in both builds.

Verification
REQ-028 The bench SHALL cover this scenario: a=15, b=15, start pulse -> done 5 edges later, product=0xE1, busy high for 5 cycles.
REQ-029 The bench SHALL cover this scenario: a=10, b=12 -> product=0x78; then a=1, b=1 -> product=0x01, with 0x78 held until the second done.
REQ-030 The bench SHALL cover this scenario: start held high continuously with a=3, b=5 -> product=0x0F, done pulses every 6 edges, with no accept during busy.
REQ-031 The bench SHALL cover this scenario: a=9, b=7 accepted, then a and b changed to 0 during CALC -> product=0x3F.
REQ-032 The bench SHALL cover this scenario: rst_n pulsed low at the 2nd CALC edge -> busy=0, product=0, and no done; a restart with a=2, b=3 -> 0x06.
REQ-033 The bench SHALL cover this scenario: a=0, b=9 -> product=0x00, with done after 1 edge when MUL4_SEQ_ZERO_SKIP_EN is defined and after 5 edges when it is not.
